// File: rtl/johnson_step_counter_pkg.sv
// Shared Johnson-code definitions for the step counter: widths, code table and index->code lookup.
// Used by johnson_step_counter (optional JCNT_ERR_CNT_EN counter) and jcnt_code_decode.
package johnson_step_counter_pkg;

    localparam int JC_W      = 4;
    localparam int JC_STATES = 8;

    localparam logic [JC_W-1:0] JC_C0 = 4'b0000;
    localparam logic [JC_W-1:0] JC_C1 = 4'b0001;
    localparam logic [JC_W-1:0] JC_C2 = 4'b0011;
    localparam logic [JC_W-1:0] JC_C3 = 4'b0111;
    localparam logic [JC_W-1:0] JC_C4 = 4'b1111;
    localparam logic [JC_W-1:0] JC_C5 = 4'b1110;
    localparam logic [JC_W-1:0] JC_C6 = 4'b1100;
    localparam logic [JC_W-1:0] JC_C7 = 4'b1000;

    function automatic logic [JC_W-1:0] jc_code(input logic [2:0] idx);
        logic [JC_W-1:0] code;
        case (idx)
            3'd0:    code = JC_C0;
            3'd1:    code = JC_C1;
            3'd2:    code = JC_C2;
            3'd3:    code = JC_C3;
            3'd4:    code = JC_C4;
            3'd5:    code = JC_C5;
            3'd6:    code = JC_C6;
            default: code = JC_C7;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/jcnt_code_decode.sv
// Combinational Johnson-code decoder: flags whether a 4-bit code is one of the 8 legal states
// and returns its index (0 for illegal codes).
module jcnt_code_decode
    import johnson_step_counter_pkg::*;
(
    input  logic [JC_W-1:0] code_i,
    output logic            legal_o,
    output logic [2:0]      idx_o
);

    always_comb begin
        legal_o = 1'b1;
        idx_o   = 3'd0;
        case (code_i)
            JC_C0:   idx_o = 3'd0;
            JC_C1:   idx_o = 3'd1;
            JC_C2:   idx_o = 3'd2;
            JC_C3:   idx_o = 3'd3;
            JC_C4:   idx_o = 3'd4;
            JC_C5:   idx_o = 3'd5;
            JC_C6:   idx_o = 3'd6;
            JC_C7:   idx_o = 3'd7;
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/johnson_step_counter.sv
// 4-bit Johnson up/down step counter with validated parallel load, wrap and illegal-load pulses.
// Define JCNT_ERR_CNT_EN to add the saturating illegal-load counter port err_cnt_o.
module johnson_step_counter
    import johnson_step_counter_pkg::*;
#(
    parameter int RESET_IDX = 0,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 dir_i,
    input  logic                 ld_i,
    input  logic [JC_W-1:0]      ld_val_i,
    output logic [JC_W-1:0]      j_o,
    output logic [2:0]           idx_o,
    output logic                 wrap_o,
`ifdef JCNT_ERR_CNT_EN
    output logic                 err_o,
    output logic [ERR_CNT_W-1:0] err_cnt_o
`else
    output logic                 err_o
`endif
);

    generate
        if (RESET_IDX < 0 || RESET_IDX > JC_STATES - 1) begin : g_bad_reset_idx
            $error("johnson_step_counter: RESET_IDX must be 0..7");
        end
        if (ERR_CNT_W < 1) begin : g_bad_err_cnt_w
            $error("johnson_step_counter: ERR_CNT_W must be >= 1");
        end
    endgenerate

    localparam logic [2:0]      RST_IDX  = 3'(RESET_IDX);
    localparam logic [JC_W-1:0] RST_CODE = jc_code(RST_IDX);

    logic [JC_W-1:0] j_q, j_d;
    logic [2:0]      idx_q, idx_d;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;
    logic            ld_legal;
    logic [2:0]      ld_idx;

    jcnt_code_decode u_ld_dec (
        .code_i  (ld_val_i),
        .legal_o (ld_legal),
        .idx_o   (ld_idx)
    );

    // Load beats step; an illegal load parks the counter at code 0 and flags it.
    always_comb begin
        j_d    = j_q;
        idx_d  = idx_q;
        wrap_d = 1'b0;
        err_d  = 1'b0;
        if (ld_i) begin
            if (ld_legal) begin
                j_d   = ld_val_i;
                idx_d = ld_idx;
            end else begin
                j_d   = JC_C0;
                idx_d = 3'd0;
                err_d = 1'b1;
            end
        end else if (en_i) begin
            if (dir_i) begin
                j_d    = {j_q[2:0], ~j_q[3]};
                idx_d  = idx_q + 3'd1;
                wrap_d = (idx_q == 3'd7);
            end else begin
                j_d    = {~j_q[0], j_q[3:1]};
                idx_d  = idx_q - 3'd1;
                wrap_d = (idx_q == 3'd0);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            j_q    <= RST_CODE;
            idx_q  <= RST_IDX;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            j_q    <= j_d;
            idx_q  <= idx_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign j_o    = j_q;
    assign idx_o  = idx_q;
    assign wrap_o = wrap_q;
    assign err_o  = err_q;

`ifdef JCNT_ERR_CNT_EN
    logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != {ERR_CNT_W{1'b1}}))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_cnt_q <= '0;
        else       err_cnt_q <= err_cnt_d;
    end

    assign err_cnt_o = err_cnt_q;
`endif

`ifndef SYNTHESIS
    // The step logic is closed over the legal set, so j must always decode and agree with idx.
    logic       chk_legal;
    logic [2:0] chk_idx;
    logic       chk_armed_q;

    jcnt_code_decode u_chk_dec (
        .code_i  (j_q),
        .legal_o (chk_legal),
        .idx_o   (chk_idx)
    );

    always_ff @(posedge clk_i) begin
        chk_armed_q <= chk_armed_q | rst_i;
        if (chk_armed_q && !rst_i)
            assert (chk_legal && (chk_idx == idx_q))
                else $error("johnson_step_counter: j/idx inconsistent j=%b idx=%0d", j_q, idx_q);
    end
`endif

endmodule

// File: tb/tb_johnson_step_counter.sv
// Self-checking bench for johnson_step_counter: directed scenarios pinned by literals plus a
// randomized phase checked every cycle against a table-driven index model.
module tb_johnson_step_counter;

    logic       clk = 1'b0;
    logic       rst, en, dir, ld;
    logic [3:0] ld_val;
    logic [3:0] j;
    logic [2:0] idx;
    logic       wrap, err;
`ifdef JCNT_ERR_CNT_EN
    logic [7:0] err_cnt;
`endif

    always #5 clk = ~clk;

    johnson_step_counter dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .dir_i     (dir),
        .ld_i      (ld),
        .ld_val_i  (ld_val),
        .j_o       (j),
        .idx_o     (idx),
        .wrap_o    (wrap),
`ifdef JCNT_ERR_CNT_EN
        .err_o     (err),
        .err_cnt_o (err_cnt)
`else
        .err_o     (err)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    // Reference model: position in the code table plus event flags.
    logic [3:0] tbl [0:7];
    int  m_idx = 0, m_cnt = 0;
    bit  m_wrap = 0, m_err = 0, m_ok = 0;

    function automatic int find_code(input logic [3:0] c);
        for (int k = 0; k < 8; k++) if (tbl[k] == c) return k;
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_idx <= 0; m_wrap <= 0; m_err <= 0; m_cnt <= 0; m_ok <= 1;
        end else if (ld) begin
            m_wrap <= 0;
            if (find_code(ld_val) >= 0) begin
                m_idx <= find_code(ld_val); m_err <= 0;
            end else begin
                m_idx <= 0; m_err <= 1; m_cnt <= (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end else if (en) begin
            m_err  <= 0;
            m_wrap <= dir ? (m_idx == 7) : (m_idx == 0);
            m_idx  <= dir ? (m_idx + 1) % 8 : (m_idx + 7) % 8;
        end else begin
            m_wrap <= 0; m_err <= 0;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            chk("model_j", int'(j), int'(tbl[m_idx]));
            chk("model_idx", int'(idx), m_idx);
            chk("model_wrap", int'(wrap), int'(m_wrap));
            chk("model_err", int'(err), int'(m_err));
`ifdef JCNT_ERR_CNT_EN
            chk("model_err_cnt", int'(err_cnt), m_cnt);
`endif
        end
    end

    task automatic step(input bit r, input bit e, input bit d, input bit l, input logic [3:0] v);
        @(negedge clk);
        rst = r; en = e; dir = d; ld = l; ld_val = v;
        @(posedge clk);
        #1;
    endtask

    logic [3:0] exp_up [0:8];

    initial begin
        tbl[0] = 4'b0000; tbl[1] = 4'b0001; tbl[2] = 4'b0011; tbl[3] = 4'b0111;
        tbl[4] = 4'b1111; tbl[5] = 4'b1110; tbl[6] = 4'b1100; tbl[7] = 4'b1000;
        exp_up[0] = 4'b0001; exp_up[1] = 4'b0011; exp_up[2] = 4'b0111; exp_up[3] = 4'b1111;
        exp_up[4] = 4'b1110; exp_up[5] = 4'b1100; exp_up[6] = 4'b1000; exp_up[7] = 4'b0000;
        exp_up[8] = 4'b0001;
        rst = 1; en = 0; dir = 0; ld = 0; ld_val = 0;

        // T1 reset then up-count through a full cycle
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_j", int'(j), 0);
        chk("rst_idx", int'(idx), 0);
        chk("rst_wrap", int'(wrap), 0);
        chk("rst_err", int'(err), 0);
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 1, 0, 0);
            chk("t1_j", int'(j), int'(exp_up[i]));
            chk("t1_idx", int'(idx), (i + 1) % 8);
            chk("t1_wrap", int'(wrap), (i == 7) ? 1 : 0);
        end

        // T2 down wrap from 0000
        step(0, 1, 0, 0, 0);
        chk("t2_pre_j", int'(j), 0);
        chk("t2_pre_wrap", int'(wrap), 0);
        step(0, 1, 0, 0, 0);
        chk("t2_j", int'(j), 4'b1000);
        chk("t2_idx", int'(idx), 7);
        chk("t2_wrap", int'(wrap), 1);
        step(0, 1, 0, 0, 0);
        chk("t2_next_j", int'(j), 4'b1100);
        chk("t2_next_idx", int'(idx), 6);
        chk("t2_next_wrap", int'(wrap), 0);

        // T6 hold at 1100 while dir toggles
        for (int i = 0; i < 5; i++) begin
            step(0, 0, i[0], 0, 4'b1111);
            chk("t6_j", int'(j), 4'b1100);
            chk("t6_idx", int'(idx), 6);
            chk("t6_wrap", int'(wrap), 0);
            chk("t6_err", int'(err), 0);
        end

        // T3 legal load beats a concurrent step
        step(0, 1, 1, 1, 4'b0111);
        chk("t3_j", int'(j), 4'b0111);
        chk("t3_idx", int'(idx), 3);
        chk("t3_err", int'(err), 0);
        chk("t3_wrap", int'(wrap), 0);
        step(0, 1, 1, 0, 0);
        chk("t3_next_j", int'(j), 4'b1111);

        // T4 illegal load
        step(0, 0, 0, 1, 4'b0101);
        chk("t4_j", int'(j), 0);
        chk("t4_idx", int'(idx), 0);
        chk("t4_err", int'(err), 1);
`ifdef JCNT_ERR_CNT_EN
        chk("t4_err_cnt", int'(err_cnt), 1);
`endif
        step(0, 0, 0, 0, 0);
        chk("t4_err_drop", int'(err), 0);
`ifdef JCNT_ERR_CNT_EN
        for (int i = 0; i < 300; i++) step(0, 0, 0, 1, 4'b1010);
        chk("t4_err_cnt_sat", int'(err_cnt), 255);
`endif

        // T5 reset dominates load and step at 1110
        step(0, 0, 0, 1, 4'b1110);
        chk("t5_pre_j", int'(j), 4'b1110);
        step(1, 1, 1, 1, 4'b0011);
        chk("t5_j", int'(j), 0);
        chk("t5_idx", int'(idx), 0);
        chk("t5_wrap", int'(wrap), 0);
        chk("t5_err", int'(err), 0);
`ifdef JCNT_ERR_CNT_EN
        chk("t5_err_cnt", int'(err_cnt), 0);
`endif

        // Randomized traffic, checked by the per-cycle model compare
        for (int i = 0; i < 600; i++) begin
            logic [3:0] v;
            v = ($urandom_range(1) == 1) ? tbl[$urandom_range(7)] : 4'($urandom_range(15));
            step($urandom_range(39) == 0, $urandom_range(3) != 0, 1'($urandom_range(1)),
                 $urandom_range(4) == 0, v);
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
